// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - program counter with relative branch and return-address stack
module pc_stack #(
    parameter int              WIDTH     = 16,
    parameter int              STEP      = 1,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       inc,
    input  logic                       rel,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           o,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf,
    output logic                       unf
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] stack [0:(2**AW)-1];
    logic [WIDTH-1:0] ret_addr;
    logic [SPW-1:0]   sp_m1;
    logic             do_push;

    assign ret_addr = o + STEP_W;
    assign sp_m1    = sp - SPW'(1);
    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);

    // ret outranks call, so a call that loses arbitration must not touch the stack
    assign do_push  = call && !ret && !full;

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            stack[sp[AW-1:0]] <= ret_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o   <= RESET_VAL;
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (ret) begin
            if (!empty) begin
                o  <= stack[sp_m1[AW-1:0]];
                sp <= sp_m1;
            end else begin
                unf <= 1'b1;
            end
        end else if (call) begin
            // the jump is taken even when the return address cannot be saved
            o <= d;
            if (!full) begin
                sp <= sp + SPW'(1);
            end else begin
                ovf <= 1'b1;
            end
        end else if (en) begin
            o <= d;
        end else if (rel) begin
            o <= o + d;
        end else if (inc) begin
            o <= o + STEP_W;
        end
    end
endmodule
